// File: rtl/plu_pkg.sv
// plu_pkg: shared definitions for the programmable logic unit.
//   plu_state_e      sweep controller state encoding (IDLE / SWEEP / DONE)
//   PLU_N_IN_MIN/MAX legal range of the N_IN parameter
package plu_pkg;

   localparam int PLU_N_IN_MIN = 2;
   localparam int PLU_N_IN_MAX = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } plu_state_e;

endpackage

// File: rtl/plu_sweep_ctrl.sv
// plu_sweep_ctrl: sweep FSM and index counter for prog_logic_unit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting; table loads and single evaluations accepted
// ST_SWEEP | one evaluation per cycle at index cnt, cnt runs 0..2**N_IN-1
// ST_DONE  | last sweep result on the outputs, done asserted for one cycle
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        sweep request, honoured only in ST_IDLE
//   cnt          current sweep index
//   sweep_eval   evaluate tt[cnt] at this edge
//   start_acc    start accepted at this edge
//   cfg_ready    high in ST_IDLE
//   busy         high in ST_SWEEP and ST_DONE
//   done         high in ST_DONE
module plu_sweep_ctrl
   import plu_pkg::*;
#(
   parameter int N_IN = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] cnt,
   output logic            sweep_eval,
   output logic            start_acc,
   output logic            cfg_ready,
   output logic            busy,
   output logic            done
);

   localparam logic [N_IN-1:0] CNT_LAST = {N_IN{1'b1}};

   plu_state_e      state_q, state_d;
   logic [N_IN-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         ST_SWEEP: begin
            // Hold at the last index instead of wrapping.
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
            else                   cnt_d   = cnt_q + N_IN'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign cnt        = cnt_q;
   assign sweep_eval = (state_q == ST_SWEEP);
   assign start_acc  = (state_q == ST_IDLE) && start;
   assign cfg_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q == ST_SWEEP) || (state_q == ST_DONE);
   assign done       = (state_q == ST_DONE);

endmodule

// File: rtl/prog_logic_unit.sv
// prog_logic_unit: programmable N_IN-input logic function backed by a
// truth table, with single evaluations and an exhaustive sweep mode.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_valid/ready    truth-table load handshake (ready only when idle)
//   cfg_data[TT_W]     new table, bit k is the output for input value k
//   in_valid, in_data  single evaluation request, result one cycle later
//   start              begin a sweep over all 2**N_IN input values
//   busy               sweep in progress (SWEEP and DONE)
//   z, z_idx, z_valid  registered result and the input value behind it
//   done               one-cycle pulse with the last sweep result
//   sig[N_IN:0]        count of ones in the last sweep; present only when
//                      PLU_SIGNATURE_EN is defined
module prog_logic_unit
   import plu_pkg::*;
#(
   parameter  int N_IN = 5,
   localparam int TT_W = 2**N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [TT_W-1:0] cfg_data,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_data,
   input  logic            start,
   output logic            busy,
   output logic            z,
   output logic            z_valid,
   output logic [N_IN-1:0] z_idx,
   output logic            done
`ifdef PLU_SIGNATURE_EN
   ,
   output logic [N_IN:0]   sig
`endif
);

   if (N_IN < PLU_N_IN_MIN || N_IN > PLU_N_IN_MAX) begin : g_bad_n_in
      $error("prog_logic_unit: N_IN out of range");
   end

   logic [N_IN-1:0] cnt;
   logic            sweep_eval;
   logic            start_acc;

   plu_sweep_ctrl #(.N_IN(N_IN)) u_sweep_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cnt        (cnt),
      .sweep_eval (sweep_eval),
      .start_acc  (start_acc),
      .cfg_ready  (cfg_ready),
      .busy       (busy),
      .done       (done)
   );

   logic [TT_W-1:0] tt_q, tt_d;
   logic            z_q, z_d;
   logic            z_valid_q, z_valid_d;
   logic [N_IN-1:0] z_idx_q, z_idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q      <= '0;
         z_q       <= 1'b0;
         z_valid_q <= 1'b0;
         z_idx_q   <= '0;
      end else begin
         tt_q      <= tt_d;
         z_q       <= z_d;
         z_valid_q <= z_valid_d;
         z_idx_q   <= z_idx_d;
      end
   end

   // A table loaded together with start becomes visible one edge before
   // the first sweep evaluation, so the sweep uses the new table.
   always_comb begin
      tt_d      = tt_q;
      z_d       = z_q;
      z_valid_d = 1'b0;
      z_idx_d   = z_idx_q;
      if (cfg_valid && cfg_ready) tt_d = cfg_data;
      if (sweep_eval) begin
         z_d       = tt_q[cnt];
         z_idx_d   = cnt;
         z_valid_d = 1'b1;
      end else if (cfg_ready && in_valid && !start) begin
         z_d       = tt_q[in_data];
         z_idx_d   = in_data;
         z_valid_d = 1'b1;
      end
   end

   assign z       = z_q;
   assign z_valid = z_valid_q;
   assign z_idx   = z_idx_q;

`ifdef PLU_SIGNATURE_EN
   logic [N_IN:0] sig_q, sig_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= '0;
      else        sig_q <= sig_d;
   end

   always_comb begin
      sig_d = sig_q;
      if (start_acc)                    sig_d = '0;
      else if (sweep_eval && tt_q[cnt]) sig_d = sig_q + (N_IN+1)'(1);
   end

   assign sig = sig_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_prog_logic_unit.sv
module tb_prog_logic_unit;

   localparam int N_IN = 5;
   localparam int TT_W = 32;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            cfg_valid = 1'b0;
   logic [TT_W-1:0] cfg_data  = '0;
   logic            in_valid  = 1'b0;
   logic [N_IN-1:0] in_data   = '0;
   logic            start     = 1'b0;
   logic            cfg_ready;
   logic            busy;
   logic            z;
   logic            z_valid;
   logic [N_IN-1:0] z_idx;
   logic            done;
`ifdef PLU_SIGNATURE_EN
   logic [N_IN:0]   sig;
`endif

   prog_logic_unit #(.N_IN(N_IN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .start     (start),
      .busy      (busy),
      .z         (z),
      .z_valid   (z_valid),
      .z_idx     (z_idx),
      .done      (done)
`ifdef PLU_SIGNATURE_EN
      ,
      .sig       (sig)
`endif
   );

   always #5 clk = ~clk;

   // Reference: the table the block should currently hold.
   logic [TT_W-1:0] tt_m = '0;
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_table(input logic [TT_W-1:0] t);
      check_val("load_ready", 64'(cfg_ready), 64'd1);
      cfg_valid = 1'b1;
      cfg_data  = t;
      tick();
      cfg_valid = 1'b0;
      tt_m      = t;
   endtask

   task automatic single_eval(input logic [N_IN-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      check_val("eval_valid", 64'(z_valid), 64'd1);
      check_val("eval_z", 64'(z), 64'(tt_m[d]));
      check_val("eval_idx", 64'(z_idx), 64'(d));
      tick();
      check_val("eval_gap_valid", 64'(z_valid), 64'd0);
      check_val("eval_hold_z", 64'(z), 64'(tt_m[d]));
      check_val("eval_hold_idx", 64'(z_idx), 64'(d));
   endtask

   task automatic run_sweep(input bit with_cfg, input logic [TT_W-1:0] new_tt,
                            input bit with_in, input bit noise);
      int busy_n;
      start = 1'b1;
      if (with_cfg) begin
         cfg_valid = 1'b1;
         cfg_data  = new_tt;
         tt_m      = new_tt;
      end
      if (with_in) begin
         in_valid = 1'b1;
         in_data  = N_IN'($urandom);
      end
      tick();
      start     = 1'b0;
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      check_val("sweep_first_busy", 64'(busy), 64'd1);
      check_val("sweep_first_valid", 64'(z_valid), 64'd0);
      busy_n = busy ? 1 : 0;
      for (int k = 0; k < TT_W; k++) begin
         tick();
         if (busy) busy_n++;
         check_val("sweep_valid", 64'(z_valid), 64'd1);
         check_val("sweep_idx", 64'(z_idx), 64'(k));
         check_val("sweep_z", 64'(z), 64'(tt_m[k]));
         check_val("sweep_done", 64'(done), 64'(k == TT_W-1));
         check_val("sweep_cfg_ready", 64'(cfg_ready), 64'd0);
`ifdef PLU_SIGNATURE_EN
         if (k == TT_W-1) check_val("sig_at_done", 64'(sig), 64'($countones(tt_m)));
`endif
         if (noise) begin
            cfg_valid = 1'($urandom);
            cfg_data  = $urandom;
            in_valid  = 1'($urandom);
            in_data   = N_IN'($urandom);
            start     = 1'($urandom);
         end
      end
      tick();
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      check_val("sweep_end_busy", 64'(busy), 64'd0);
      check_val("sweep_end_valid", 64'(z_valid), 64'd0);
      check_val("sweep_end_done", 64'(done), 64'd0);
      check_val("sweep_end_idx_hold", 64'(z_idx), 64'(TT_W-1));
      check_val("sweep_busy_cycles", 64'(busy_n), 64'(TT_W+1));
`ifdef PLU_SIGNATURE_EN
      check_val("sig_hold", 64'(sig), 64'($countones(tt_m)));
`endif
   endtask

   initial begin
      repeat (2) tick();
      check_val("rst_z", 64'(z), 64'd0);
      check_val("rst_z_valid", 64'(z_valid), 64'd0);
      check_val("rst_z_idx", 64'(z_idx), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      rst_n = 1'b1;
      tick();
      single_eval(N_IN'($urandom));

      // 5-input XOR table, known-answer evaluation of 5'b10110.
      load_table(32'h96696996);
      single_eval(5'b10110);
      check_val("xor_22_z", 64'(z), 64'd1);

      // Sweep with ignored cfg/in/start noise; old table must survive.
      run_sweep(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) single_eval(N_IN'($urandom));

      // start together with in_valid: evaluation dropped, sweep from 0.
      run_sweep(1'b0, '0, 1'b1, 1'b0);

      for (int r = 0; r < 4; r++) begin
         load_table($urandom);
         for (int i = 0; i < 8; i++) single_eval(N_IN'($urandom));
         run_sweep(1'b1, $urandom, 1'b0, 1'b0);
         single_eval(N_IN'($urandom));
      end

      load_table('0);
      run_sweep(1'b0, '0, 1'b0, 1'b0);

      // Reset in the middle of a sweep.
      load_table(32'h96696996);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         tick();
         check_val("abort_idx", 64'(z_idx), 64'(k));
      end
      rst_n = 1'b0;
      #1;
      check_val("abort_z", 64'(z), 64'd0);
      check_val("abort_valid", 64'(z_valid), 64'd0);
      check_val("abort_idx0", 64'(z_idx), 64'd0);
      check_val("abort_done", 64'(done), 64'd0);
      check_val("abort_busy", 64'(busy), 64'd0);
      tt_m = '0;
      repeat (3) begin
         tick();
         check_val("abort_no_done", 64'(done), 64'd0);
      end
      rst_n = 1'b1;
      tick();
      check_val("after_rst_busy", 64'(busy), 64'd0);
      single_eval(5'b10110);
      run_sweep(1'b0, '0, 1'b0, 1'b0);
      load_table($urandom);
      run_sweep(1'b0, '0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
